// File: rtl/game_controller.sv
// Level/lives sequencer: runs the title/play/transition/end-of-game flow and
// drives a registered active-low reset to the player and monster blocks.
module game_controller #(
  parameter int                     NUMBER_OF_LEVELS  = 3,
  parameter int                     LEVEL_WIDTH       = 2,
  parameter int                     INITIAL_LIVES     = 3,
  parameter int                     LIVES_WIDTH       = 2,
  parameter int                     TRANSITION_FRAMES = 60,
  parameter int                     FRAME_COUNT_WIDTH = 8,
  parameter int                     KEYCODE_WIDTH     = 9,
  parameter logic [KEYCODE_WIDTH-1:0] START_KEY       = 9'h029
) (
  input  logic                     clk,
  input  logic                     resetN,
  input  logic                     startOfFrame,
  input  logic [KEYCODE_WIDTH-1:0] keyCode,
  input  logic                     make,
  input  logic                     all_monsters_dead,
  input  logic                     player_hit,
  output logic                     level_resetN,
  output logic                     level_start,
  output logic [LEVEL_WIDTH-1:0]   level,
  output logic [LIVES_WIDTH-1:0]   lives,
  output logic                     game_active,
  output logic                     game_over,
  output logic                     game_won
);

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_PLAYING     = 3'd1,
    S_LEVEL_CLEAR = 3'd2,
    S_DYING       = 3'd3,
    S_GAME_OVER   = 3'd4,
    S_WIN         = 3'd5
  } state_t;

  localparam logic [LEVEL_WIDTH-1:0]       L_LAST_LEVEL = LEVEL_WIDTH'(NUMBER_OF_LEVELS - 1);
  localparam logic [LIVES_WIDTH-1:0]       L_INIT_LIVES = LIVES_WIDTH'(INITIAL_LIVES);
  localparam logic [FRAME_COUNT_WIDTH-1:0] L_LAST_FRAME = FRAME_COUNT_WIDTH'(TRANSITION_FRAMES - 1);

  state_t                       r_state;
  state_t                       w_next_state;
  logic [LEVEL_WIDTH-1:0]       r_level;
  logic [LEVEL_WIDTH-1:0]       w_next_level;
  logic [LIVES_WIDTH-1:0]       r_lives;
  logic [LIVES_WIDTH-1:0]       w_next_lives;
  logic [FRAME_COUNT_WIDTH-1:0] r_frame_cnt;
  logic [FRAME_COUNT_WIDTH-1:0] w_next_frame_cnt;
  logic                         r_level_resetN;
  logic                         r_level_start;
  logic                         r_game_active;
  logic                         r_game_over;
  logic                         r_game_won;
  logic                         w_start;

  assign w_start = make && (keyCode == START_KEY);

  // Next-state, level, lives and frame-counter decode.
  always_comb begin
    w_next_state     = r_state;
    w_next_level     = r_level;
    w_next_lives     = r_lives;
    w_next_frame_cnt = r_frame_cnt;
    case (r_state)
      S_IDLE, S_GAME_OVER, S_WIN: begin
        if (w_start) begin
          w_next_state = S_PLAYING;
          w_next_level = {LEVEL_WIDTH{1'b0}};
          w_next_lives = L_INIT_LIVES;
        end else begin
          w_next_state = r_state;
        end
      end
      S_PLAYING: begin
        // Counter is cleared here so every transition state starts from zero.
        w_next_frame_cnt = {FRAME_COUNT_WIDTH{1'b0}};
        if (r_level_start) begin
          w_next_state = S_PLAYING;
        end else if (player_hit) begin
          if (r_lives > LIVES_WIDTH'(1)) begin
            w_next_state = S_DYING;
            w_next_lives = r_lives - LIVES_WIDTH'(1);
          end else begin
            w_next_state = S_GAME_OVER;
            w_next_lives = {LIVES_WIDTH{1'b0}};
          end
        end else if (all_monsters_dead) begin
          if (r_level < L_LAST_LEVEL) begin
            w_next_state = S_LEVEL_CLEAR;
          end else begin
            w_next_state = S_WIN;
          end
        end else begin
          w_next_state = S_PLAYING;
        end
      end
      S_LEVEL_CLEAR, S_DYING: begin
        if (startOfFrame) begin
          if (r_frame_cnt == L_LAST_FRAME) begin
            w_next_state     = S_PLAYING;
            w_next_frame_cnt = {FRAME_COUNT_WIDTH{1'b0}};
            if ((r_state == S_LEVEL_CLEAR) && (r_level < L_LAST_LEVEL)) begin
              w_next_level = r_level + LEVEL_WIDTH'(1);
            end else begin
              w_next_level = r_level;
            end
          end else begin
            w_next_frame_cnt = r_frame_cnt + FRAME_COUNT_WIDTH'(1);
          end
        end else begin
          w_next_frame_cnt = r_frame_cnt;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // State, counters and outputs, with outputs decoded from the next state.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state        <= S_IDLE;
      r_level        <= {LEVEL_WIDTH{1'b0}};
      r_lives        <= L_INIT_LIVES;
      r_frame_cnt    <= {FRAME_COUNT_WIDTH{1'b0}};
      r_level_resetN <= 1'b0;
      r_level_start  <= 1'b0;
      r_game_active  <= 1'b0;
      r_game_over    <= 1'b0;
      r_game_won     <= 1'b0;
    end else begin
      r_state        <= w_next_state;
      r_level        <= w_next_level;
      r_lives        <= w_next_lives;
      r_frame_cnt    <= w_next_frame_cnt;
      r_level_resetN <= (w_next_state == S_PLAYING);
      r_level_start  <= (w_next_state == S_PLAYING) && (r_state != S_PLAYING);
      r_game_active  <= (w_next_state == S_PLAYING) || (w_next_state == S_LEVEL_CLEAR) ||
                        (w_next_state == S_DYING);
      r_game_over    <= (w_next_state == S_GAME_OVER);
      r_game_won     <= (w_next_state == S_WIN);
    end
  end

  assign level_resetN = r_level_resetN;
  assign level_start  = r_level_start;
  assign level        = r_level;
  assign lives        = r_lives;
  assign game_active  = r_game_active;
  assign game_over    = r_game_over;
  assign game_won     = r_game_won;

endmodule
